// File: rtl/vecmac_pkg.sv
// Shared definitions for the int8 vector-MAC datapath: default widths and
// the accumulator FSM state encoding.
package vecmac_pkg;

  localparam int DEF_IN_W  = 18;
  localparam int DEF_ACC_W = 32;
  localparam int DEF_LEN_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/vec_accumulator.sv
// Accumulates a programmed number of adder-tree partial sums into one
// dot-product result and holds it on a valid/ready port until taken.
module vec_accumulator
  import vecmac_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  sum,
  output logic             busy,
  output logic             in_drop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow
);

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic [ACC_W:0]   acc_next;

  // One bit wider than the accumulator so the carry out of the top bit is visible.
  always_comb begin
    acc_next = {1'b0, acc_out} + {{(ACC_W + 1 - IN_W){1'b0}}, sum};
  end

  // FSM, beat counter, accumulator and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      acc_out   <= '0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      in_drop   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_drop <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_drop <= 1'b1;
          end
          if (start) begin
            remaining <= len;
            acc_out   <= '0;
            overflow  <= 1'b0;
            busy      <= 1'b1;
            if (len == '0) begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_out   <= acc_next[ACC_W-1:0];
            remaining <= remaining - LEN_W'(1);
            if (acc_next[ACC_W]) begin
              overflow <= 1'b1;
            end
            if (remaining == LEN_W'(1)) begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (in_valid) begin
            in_drop <= 1'b1;
          end
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_accumulator.sv
// Self-checking bench for vec_accumulator: a 32-bit and a 20-bit instance
// share one stimulus stream and are compared every cycle against an
// exact-sum behavioural model, plus directed scenarios with literal results.
module tb_vec_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        in_valid = 1'b0;
  logic [17:0] sum = '0;
  logic        out_ready = 1'b0;

  logic        busy, in_drop, out_valid, overflow;
  logic [31:0] acc_out;
  logic        busy20, in_drop20, out_valid20, overflow20;
  logic [19:0] acc_out20;

  int checks = 0;
  int errors = 0;

  // Model state: exact (unbounded) running sum and handshake status.
  bit      model_live = 0;
  bit      m_busy = 0;
  bit      m_valid = 0;
  bit      m_drop = 0;
  int      m_left = 0;
  longint  m_total = 0;

  vec_accumulator #(.IN_W(18), .ACC_W(32), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .sum(sum), .busy(busy), .in_drop(in_drop),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
    .overflow(overflow)
  );

  vec_accumulator #(.IN_W(18), .ACC_W(20), .LEN_W(8)) dut20 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .sum(sum), .busy(busy20), .in_drop(in_drop20),
    .out_valid(out_valid20), .out_ready(out_ready), .acc_out(acc_out20),
    .overflow(overflow20)
  );

  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [7:0] l, input logic iv,
                               input logic [17:0] s, input logic rdy);
    @(negedge clk);
    start     = st;
    len       = l;
    in_valid  = iv;
    sum       = s;
    out_ready = rdy;
  endtask

  function automatic logic [63:0] expAcc(input int w);
    return 64'(m_total) & ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] expOvf(input int w);
    return {63'd0, (m_total >= (longint'(1) << w))};
  endfunction

  // Behavioural model: reacts to the inputs sampled at each rising edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      model_live = 1;
      m_busy = 0; m_valid = 0; m_drop = 0; m_left = 0; m_total = 0;
    end else begin
      m_drop = 0;
      if (!m_busy) begin
        m_drop = in_valid;
        if (start) begin
          m_total = 0;
          m_left  = int'(len);
          m_busy  = 1;
          m_valid = (len == 0);
        end
      end else if (!m_valid) begin
        if (in_valid) begin
          m_total += longint'(sum);
          m_left--;
          if (m_left == 0) m_valid = 1;
        end
      end else begin
        m_drop = in_valid;
        if (out_ready) begin
          m_valid = 0;
          m_busy  = 0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of both instances against the model.
  always @(posedge clk) begin
    #2;
    if (model_live) begin
      checkOutput("busy",       {63'd0, busy},       {63'd0, m_busy});
      checkOutput("in_drop",    {63'd0, in_drop},    {63'd0, m_drop});
      checkOutput("out_valid",  {63'd0, out_valid},  {63'd0, m_valid});
      checkOutput("acc_out",    64'(acc_out),        expAcc(32));
      checkOutput("overflow",   {63'd0, overflow},   expOvf(32));
      checkOutput("busy20",     {63'd0, busy20},     {63'd0, m_busy});
      checkOutput("in_drop20",  {63'd0, in_drop20},  {63'd0, m_drop});
      checkOutput("out_valid20",{63'd0, out_valid20},{63'd0, m_valid});
      checkOutput("acc_out20",  64'(acc_out20),      expAcc(20));
      checkOutput("overflow20", {63'd0, overflow20}, expOvf(20));
    end
  end

  initial begin
    // Reset and its output values.
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst_busy",      {63'd0, busy},      64'd0);
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_acc",       64'(acc_out),       64'd0);
    checkOutput("rst_overflow",  {63'd0, overflow},  64'd0);

    // len=4, beats 1..4 back-to-back, sink ready.
    applyStimulus(1, 4, 0, 0, 1);
    applyStimulus(0, 0, 1, 1, 1);
    checkOutput("t1_busy", {63'd0, busy}, 64'd1);
    applyStimulus(0, 0, 1, 2, 1);
    applyStimulus(0, 0, 1, 3, 1);
    applyStimulus(0, 0, 1, 4, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t1_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("t1_acc",   64'(acc_out),       64'd10);
    checkOutput("t1_ovf",   {63'd0, overflow},  64'd0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t1_busy_after", {63'd0, busy}, 64'd0);

    // len=3 with gaps, sink stalls for five cycles.
    applyStimulus(1, 3, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 18'h3FFFC, 0);
      if (i < 2) applyStimulus(0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("t2_hold_valid", {63'd0, out_valid}, 64'd1);
      checkOutput("t2_hold_acc",   64'(acc_out),       64'hBFFF4);
    end
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t2_released", {63'd0, out_valid}, 64'd0);

    // len=5 of the maximum partial sum: wraps the 20-bit accumulator.
    applyStimulus(1, 5, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 18'h3FFFC, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t3_acc20", 64'(acc_out20),       64'h3FFEC);
    checkOutput("t3_ovf20", {63'd0, overflow20},  64'd1);
    checkOutput("t3_acc32", 64'(acc_out),         64'h13FFEC);
    checkOutput("t3_ovf32", {63'd0, overflow},    64'd0);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);

    // len=0 with a beat alongside start, a beat in HOLD, a beat in IDLE.
    applyStimulus(1, 0, 1, 18'h155, 0);
    applyStimulus(0, 0, 1, 18'h2AA, 0);
    checkOutput("t4_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("t4_acc",   64'(acc_out),       64'd0);
    checkOutput("t4_drop_start", {63'd0, in_drop}, 64'd1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t4_drop_hold", {63'd0, in_drop}, 64'd1);
    applyStimulus(0, 0, 1, 18'h3, 0);
    checkOutput("t4_idle_valid", {63'd0, out_valid}, 64'd0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t4_drop_idle", {63'd0, in_drop}, 64'd1);
    checkOutput("t4_acc_kept",  64'(acc_out),     64'd0);

    // Reset mid-accumulation, then a fresh run.
    applyStimulus(1, 4, 0, 0, 0);
    applyStimulus(0, 0, 1, 5, 0);
    applyStimulus(0, 0, 1, 6, 0);
    applyStimulus(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("t5_rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("t5_rst_acc",  64'(acc_out),  64'd0);
    applyStimulus(1, 2, 0, 0, 1);
    applyStimulus(0, 0, 1, 7, 1);
    applyStimulus(0, 0, 1, 8, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t5_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("t5_acc",   64'(acc_out),       64'd15);

    // start during ACCUM and on the handshake cycle is ignored.
    applyStimulus(1, 2, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(1, 7, 1, 2, 0);
    applyStimulus(1, 1, 0, 0, 1);
    checkOutput("t6_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("t6_acc",   64'(acc_out),       64'd3);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t6_busy_after", {63'd0, busy},      64'd0);
    checkOutput("t6_valid_after",{63'd0, out_valid}, 64'd0);

    // Randomized traffic, including occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_n     = ($urandom_range(0, 199) != 0);
      start     = ($urandom_range(0, 3) == 0);
      len       = 8'($urandom_range(0, 9));
      in_valid  = ($urandom_range(0, 2) != 0);
      sum       = ($urandom_range(0, 7) == 0) ? 18'h3FFFC : 18'($urandom_range(0, 262140));
      out_ready = ($urandom_range(0, 1) == 1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
